vreduction_wb_buffer: RTL and testbench
=======================================

Name: vreduction_wb_buffer

Overview:
- Sits directly downstream of the vector reduction unit and between it and register-file writeback.
- The reduction unit has no stall input, so this block reserves a buffer slot at issue time. It gives the issuer a credit signal so a reduction is only launched when its result is guaranteed a slot.
- It captures each result vector with its destination tag, in order, and presents results to writeback over a valid/ready handshake.

Parameters:
- ELEMS, 16, vector elements per result.
- DATA_W, 16, bits per element (fp16).
- TAG_W, 5, destination register tag width.
- DEPTH, 4, slots; power of two, >= 2.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  reduction op launched into the reduction unit this cycle.
- issue_tag  in  TAG_W  destination tag of the launched op.
- issue_ok  out  1  a free slot exists; issuer launches only when high.
- res_valid  in  1  reduction unit output_valid.
- res_data  in  ELEMS*DATA_W  reduction unit vector output; element i at bits [i*DATA_W +: DATA_W].
- wb_valid  out  1  head result ready for writeback.
- wb_ready  in  1  writeback accepts the head result.
- wb_data  out  ELEMS*DATA_W  head result vector.
- wb_tag  out  TAG_W  head result tag.
- occupancy  out  clog2(DEPTH)+1  slots allocated, counting both pending and filled slots.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Storage and pointers:
  - Circular buffer of DEPTH slots; each slot holds tag, data and a filled bit.
  - Three pointers, each clog2(DEPTH)+1 bits with a wrap bit: alloc, fill, head.
  - occupancy = alloc - head, modulo arithmetic.
  - pending = alloc - fill.
- Reset: all pointers 0, filled bits 0, err 0, wb_valid 0, issue_ok 1, occupancy 0. wb_data and wb_tag read as 0 while empty.
- issue_ok = (occupancy < DEPTH), computed from registered state only; it does not depend on wb_ready in the same cycle.
- Issue:
  - issue_valid && issue_ok: write issue_tag into slot[alloc], clear its filled bit, alloc++.
  - issue_valid && !issue_ok: op dropped, err set.
- Result:
  - res_valid && pending > 0: write res_data into slot[fill], set filled, fill++.
  - res_valid && pending == 0: result dropped, err set.
- Writeback:
  - wb_valid = (occupancy > 0) && slot[head].filled. Results are delivered strictly in issue order; a filled slot behind an unfilled head waits.
  - wb_data and wb_tag come from slot[head] combinationally (first-word fall-through).
  - wb_valid && wb_ready: clear slot[head].filled, head++.
  - wb_data and wb_tag must hold stable while wb_valid && !wb_ready.
- Latency:
  - res_valid in cycle t into an empty-headed buffer gives wb_valid in cycle t+1.
  - A pop in cycle t frees its credit; issue_ok rises in cycle t+1.
- Simultaneous events: issue, result and pop may all occur in one cycle. Each acts on its own pointer, and occupancy updates by (+issue -pop).
  - With occupancy == DEPTH, a same-cycle pop does not make an issue legal (issue_ok is already 0).
  - Same-cycle fill and pop of the head slot cannot happen, because filled is registered.
- Wrap-around: pointers wrap modulo 2*DEPTH; the slot index is the low clog2(DEPTH) bits.
- err: sticky once set; cleared only by reset.
- Reset mid-operation: all slots, pointers and pending state are discarded. The issuer is responsible for flushing the reduction unit at the same reset.

Test Plan:
- Single op: issue tag 3, res_valid 7 cycles later with all elements 0x3C00, wb_ready=1 -> wb_valid for exactly 1 cycle with tag 3, data all 0x3C00; occupancy returns to 0.
- Fill credits: 4 back-to-back issues (tags 1,2,3,4), wb_ready=0 -> issue_ok low after 4th issue, occupancy 4. A 5th issue_valid sets err and leaves occupancy at 4.
- Backpressure: 3 results buffered, wb_ready toggled 1,0,1 -> tags popped in order 1,2,3 with data stable during the stall. issue_ok rises the cycle after the first pop.
- Wrap-around: 10 sequential issue/result/pop rounds with distinct tags 0..9 -> all delivered in order, err stays 0.
- Simultaneous: at occupancy 2 with head filled, issue + res_valid + pop in the same cycle -> occupancy stays 2, fill advances, new tag stored, popped tag correct.
- Spurious result: res_valid with no issue pending -> err=1, wb_valid stays 0. Assert nRST mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/vreduction_wb_buffer.sv
// Writeback buffer between the vector reduction unit and register-file writeback.
// Slots are reserved at issue time, filled in order by results and drained in order to writeback.

module vreduction_wb_slot #(
    parameter int TAG_W = 5,
    parameter int VW    = 256
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_issue,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_fill,
    input  logic [VW-1:0]    i_data,
    input  logic             i_pop,
    output logic [TAG_W-1:0] o_tag,
    output logic [VW-1:0]    o_data,
    output logic             o_filled
);
    logic [TAG_W-1:0] r_tag;
    logic [VW-1:0]    r_data;
    logic             r_filled;

    // Issue, fill and pop never target the same slot in one cycle, so their order here is immaterial.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_tag    <= '0;
            r_data   <= '0;
            r_filled <= 1'b0;
        end else begin
            if (i_issue) begin
                r_tag    <= i_tag;
                r_filled <= 1'b0;
            end
            if (i_fill) begin
                r_data   <= i_data;
                r_filled <= 1'b1;
            end
            if (i_pop)
                r_filled <= 1'b0;
        end
    end

    assign o_tag    = r_tag;
    assign o_data   = r_data;
    assign o_filled = r_filled;
endmodule

module vreduction_wb_buffer #(
    parameter int ELEMS  = 16,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = 4,
    localparam int VW    = ELEMS * DATA_W,
    localparam int IW    = $clog2(DEPTH),
    localparam int PW    = IW + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             issue_ok,
    input  logic             res_valid,
    input  logic [VW-1:0]    res_data,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [VW-1:0]    wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic [PW-1:0]    occupancy,
    output logic             err
);
    logic [PW-1:0] r_alloc, r_fill, r_head;
    logic          r_err;

    logic [PW-1:0] w_occ, w_pend;
    logic [IW-1:0] w_alloc_idx, w_fill_idx, w_head_idx;
    logic          w_do_issue, w_do_fill, w_do_pop;
    logic          w_issue_ok, w_wb_valid;

    logic [DEPTH-1:0][TAG_W-1:0] w_slot_tag;
    logic [DEPTH-1:0][VW-1:0]    w_slot_data;
    logic [DEPTH-1:0]            w_slot_filled;

    // Wrap bit in each pointer distinguishes full from empty.
    assign w_occ       = r_alloc - r_head;
    assign w_pend      = r_alloc - r_fill;
    assign w_alloc_idx = r_alloc[IW-1:0];
    assign w_fill_idx  = r_fill[IW-1:0];
    assign w_head_idx  = r_head[IW-1:0];

    assign w_issue_ok = (w_occ < PW'(DEPTH));
    assign w_wb_valid = (w_occ != '0) && w_slot_filled[w_head_idx];
    assign w_do_issue = issue_valid && w_issue_ok;
    assign w_do_fill  = res_valid && (w_pend != '0);
    assign w_do_pop   = w_wb_valid && wb_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        vreduction_wb_slot #(.TAG_W(TAG_W), .VW(VW)) u_slot (
            .CLK      (CLK),
            .nRST     (nRST),
            .i_issue  (w_do_issue && (w_alloc_idx == IW'(g))),
            .i_tag    (issue_tag),
            .i_fill   (w_do_fill && (w_fill_idx == IW'(g))),
            .i_data   (res_data),
            .i_pop    (w_do_pop && (w_head_idx == IW'(g))),
            .o_tag    (w_slot_tag[g]),
            .o_data   (w_slot_data[g]),
            .o_filled (w_slot_filled[g])
        );
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_alloc <= '0;
            r_fill  <= '0;
            r_head  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_do_issue) r_alloc <= r_alloc + PW'(1);
            if (w_do_fill)  r_fill  <= r_fill + PW'(1);
            if (w_do_pop)   r_head  <= r_head + PW'(1);
            // Dropped issues and orphan results are unrecoverable; latch until reset.
            if ((issue_valid && !w_issue_ok) || (res_valid && (w_pend == '0)))
                r_err <= 1'b1;
        end
    end

    assign issue_ok  = w_issue_ok;
    assign wb_valid  = w_wb_valid;
    assign wb_data   = (w_occ != '0) ? w_slot_data[w_head_idx] : '0;
    assign wb_tag    = (w_occ != '0) ? w_slot_tag[w_head_idx]  : '0;
    assign occupancy = w_occ;
    assign err       = r_err;
endmodule

// File: tb/tb_vreduction_wb_buffer.sv
// Scoreboard bench: stimulus queues expected writebacks, a negedge monitor checks every output.

module tb_vreduction_wb_buffer;
    localparam int ELEMS  = 16;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 5;
    localparam int DEPTH  = 4;
    localparam int VW     = ELEMS * DATA_W;
    localparam int PW     = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             issue_valid, res_valid, wb_ready;
    logic [TAG_W-1:0] issue_tag;
    logic [VW-1:0]    res_data;
    logic             issue_ok, wb_valid, err;
    logic [VW-1:0]    wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic [PW-1:0]    occupancy;

    vreduction_wb_buffer #(.ELEMS(ELEMS), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRST(nRST),
        .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ok(issue_ok),
        .res_valid(res_valid), .res_data(res_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag),
        .occupancy(occupancy), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [TAG_W-1:0] tag; logic [VW-1:0] data; } exp_t;
    exp_t             sb[$];
    logic [TAG_W-1:0] tagq[$];

    // Reference model: counts of allocated, awaiting-result and ready-to-write slots.
    int   m_occ = 0, m_pend = 0, m_filled = 0;
    logic m_err = 1'b0;
    int   tests = 0, fails = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (!nRST) begin
            check("rst_occ", VW'(occupancy), 0);
            check("rst_issue_ok", VW'(issue_ok), 1);
            check("rst_wb_valid", VW'(wb_valid), 0);
            check("rst_err", VW'(err), 0);
            check("rst_wb_data", wb_data, 0);
            check("rst_wb_tag", VW'(wb_tag), 0);
            m_occ = 0; m_pend = 0; m_filled = 0; m_err = 1'b0;
            sb.delete();
        end else begin
            automatic logic exp_valid = (m_filled > 0);
            automatic logic do_pop;
            check("occupancy", VW'(occupancy), VW'(m_occ));
            check("issue_ok", VW'(issue_ok), VW'(m_occ < DEPTH));
            check("err", VW'(err), VW'(m_err));
            check("wb_valid", VW'(wb_valid), VW'(exp_valid));
            if (m_occ == 0) begin
                check("empty_data", wb_data, 0);
                check("empty_tag", VW'(wb_tag), 0);
            end
            if (exp_valid && sb.size() > 0) begin
                check("wb_tag", VW'(wb_tag), VW'(sb[0].tag));
                check("wb_data", wb_data, sb[0].data);
            end
            do_pop = exp_valid && wb_ready;
            if (do_pop) begin
                void'(sb.pop_front());
                m_filled--;
                m_occ--;
            end
            if (res_valid) begin
                if (m_pend > 0) begin m_pend--; m_filled++; end
                else m_err = 1'b1;
            end
            if (issue_valid) begin
                // Legality uses occupancy before this cycle's pop.
                if (m_occ + (do_pop ? 1 : 0) < DEPTH) begin m_occ++; m_pend++; end
                else m_err = 1'b1;
            end
        end
    end

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < VW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step(input logic iv, input logic [TAG_W-1:0] t, input logic rv,
                        input logic [VW-1:0] d, input logic wr);
        exp_t e;
        issue_valid = iv; issue_tag = t; res_valid = rv; res_data = d; wb_ready = wr;
        if (rv && tagq.size() > 0) begin
            e.tag = tagq.pop_front();
            e.data = d;
            sb.push_back(e);
        end
        if (iv && m_occ < DEPTH) tagq.push_back(t);
        @(posedge CLK); #1;
    endtask

    task automatic idle(input int n, input logic wr);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, wr);
    endtask

    task automatic do_reset();
        issue_valid = 0; res_valid = 0; wb_ready = 0; issue_tag = '0; res_data = '0;
        nRST = 1'b0;
        tagq.delete();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    task automatic drain();
        int budget;
        while (tagq.size() > 0) step(1'b0, '0, 1'b1, rand_vec(), 1'b1);
        budget = 0;
        while (sb.size() > 0 && budget < 100) begin idle(1, 1'b1); budget++; end
        check("drain_empty", VW'(sb.size()), 0);
    endtask

    logic [VW-1:0] ones_h;

    initial begin
        nRST = 1'b0;
        issue_valid = 0; res_valid = 0; wb_ready = 0; issue_tag = '0; res_data = '0;
        for (int k = 0; k < ELEMS; k++) ones_h[k*DATA_W +: DATA_W] = 16'h3C00;
        @(posedge CLK); #1;
        do_reset();
        idle(2, 1'b1);

        // Single op, result 7 cycles after issue
        step(1'b1, 5'd3, 1'b0, '0, 1'b1);
        idle(6, 1'b1);
        step(1'b0, '0, 1'b1, ones_h, 1'b1);
        idle(3, 1'b1);

        // Fill credits, overflow issue, then in-order drain under backpressure
        for (int k = 1; k <= 4; k++) step(1'b1, TAG_W'(k), 1'b0, '0, 1'b0);
        step(1'b1, 5'd5, 1'b0, '0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, rand_vec(), 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        idle(1, 1'b1);
        drain();
        do_reset();

        // Wrap-around with sequential rounds
        for (int k = 0; k < 10; k++) begin
            step(1'b1, TAG_W'(k), 1'b0, '0, 1'b1);
            step(1'b0, '0, 1'b1, rand_vec(), 1'b1);
            idle(2, 1'b1);
        end

        // Issue + fill + pop in one cycle at occupancy 2 with head filled
        step(1'b1, 5'd20, 1'b0, '0, 1'b0);
        step(1'b1, 5'd21, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, rand_vec(), 1'b0);
        idle(1, 1'b0);
        step(1'b1, 5'd22, 1'b1, rand_vec(), 1'b1);
        idle(1, 1'b0);
        drain();

        // Orphan result, then reset in the middle of traffic
        step(1'b0, '0, 1'b1, rand_vec(), 1'b1);
        idle(1, 1'b1);
        step(1'b1, 5'd7, 1'b0, '0, 1'b0);
        step(1'b1, 5'd8, 1'b1, rand_vec(), 1'b0);
        do_reset();
        idle(2, 1'b1);

        // Randomized traffic with occasional overflow, orphan results and resets
        for (int i = 0; i < 3000; i++) begin
            automatic logic iv = ($urandom_range(0, 2) == 0);
            automatic logic rv = (tagq.size() > 0 && $urandom_range(0, 1) == 1) ||
                                 ($urandom_range(0, 299) == 0);
            automatic logic wr = ($urandom_range(0, 3) != 0);
            if (i % 1000 == 999) do_reset();
            else step(iv, TAG_W'($urandom_range(0, 31)), rv, rand_vec(), wr);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
